phase_timer: RTL
================

# phase_timer

Per-phase countdown timer that drives the traffic-light controller FSM. It watches the FSM's one-hot phase indicators (`fsm_r`, `fsm_y`, `fsm_g`) and loads the programmed duration for the active phase. It counts that duration down in whole seconds and returns a single-cycle `r_end`/`y_end`/`g_end` pulse when the phase expires. It also holds the three user-programmable durations, which are edited while `set_mode` is high, and exposes the remaining seconds for the display stage.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per second; must be ≥ 2.
- `R_DEF`, 3: reset value of red duration, in seconds (1..99).
- `Y_DEF`, 3: reset value of yellow duration, in seconds (1..99).
- `G_DEF`, 10: reset value of green duration, in seconds (1..99).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `fsm_r`, `fsm_y`, `fsm_g`  in  1 each  phase indicators from the controller FSM; at most one is high.
- `set_mode`  in  1  level; configuration mode.
- `sel`  in  2  duration to edit: 0 red, 1 yellow, 2 green, 3 none.
- `inc`  in  1  single-cycle pulse; increments the selected duration.
- `r_end`, `y_end`, `g_end`  out  1 each  single-cycle registered end-of-phase pulses.
- `remain`  out  7  seconds remaining in the current phase (unsigned binary).
- `tick`  out  1  one-second strobe, combinational; high one cycle per second while counting.

## Operation
- **Registers:**
  - `dur_r`, `dur_y`, `dur_g`: 7 bits each, legal range 1..99.
  - `cnt`: 7 bits.
  - `pre`: prescaler, clog2(TICK_DIV) bits.
  - `prev`: 3 bits, last-seen `{fsm_r, fsm_y, fsm_g}`.
  - state: IDLE / RUN / DONE.
- **Reset (`rst` = 0):**
  - durations = R_DEF / Y_DEF / G_DEF.
  - `cnt` = 0, `pre` = 0, `prev` = 000, state = IDLE.
  - all `*_end` = 0, `remain` = 0, `tick` = 0.
- **Phase vector** `ph = {fsm_r, fsm_y, fsm_g}`. It is legal only when it is exactly one-hot.
- **Priority, highest first:** reset > `set_mode` > reload > tick.
- **Duration editing:**
  - Applies only on an edge where `set_mode` && `inc` && `sel` != 3.
  - The selected duration becomes `dur + 1`, or 1 if `dur` == 99.
  - `inc` is ignored when `set_mode` = 0.
- **`set_mode` = 1:** every cycle, `cnt` ← duration of the active phase (0 if `ph` is illegal), `pre` ← 0, `prev` ← `ph`, state ← RUN (IDLE if `ph` is illegal). No end pulses are generated.
- **Reload:**
  - Triggered when `ph` != `prev` and `set_mode` = 0.
  - `prev` ← `ph`, `pre` ← 0.
  - Legal `ph`: `cnt` ← matching duration, state ← RUN.
  - Illegal `ph`: `cnt` ← 0, state ← IDLE.
- **RUN:**
  - `pre` increments each cycle; `tick` = (`pre` == TICK_DIV−1).
  - On a tick, `pre` ← 0.
  - On a tick with `cnt` > 1: `cnt` ← `cnt` − 1.
  - On a tick with `cnt` == 1: `cnt` ← 0, the end pulse of the active phase is registered high for one cycle, state ← DONE.
- **DONE:** `cnt` is held at 0, `pre` is frozen, `tick` = 0. No further pulses until a reload or `set_mode`.
- **IDLE:** nothing counts and no pulses are generated.
- **Outputs:** `remain` = `cnt`. At most one `*_end` is high in any cycle.
- **Phase sequencing:** the controller always alternates phase kinds (R→Y→G→R…), so change detection reliably restarts each phase. An early phase change from the controller (manual step) simply reloads; the abandoned phase never pulses.

## Timing
- **Reload latency:** a `ph` change visible in cycle n loads `cnt` at edge n+1.
- **End-pulse time:** with duration D, the end pulse is high during the cycle that starts exactly D·TICK_DIV edges after the reload edge. `remain` steps D, D−1, …, 1, 0, changing every TICK_DIV edges.
- **Reload and tick in the same cycle:** reload wins; no decrement, no end pulse.
- **`set_mode` and end condition in the same cycle:** `set_mode` wins; no pulse.
- **Leaving `set_mode`:** counting begins with `pre` = 0 on the first cycle after `set_mode` falls.
- **Reset mid-count:** all state returns to reset values at that edge. The first legal `ph` after reset reloads at the next edge (`prev` = 000 differs).
- **FSM handoff:** the end pulse lasts exactly one cycle, so the FSM advances exactly once per expiry.

## Test plan
- **Nominal red phase:**
  - Stimulus: TICK_DIV = 4, reset released, `ph` = 100.
  - Response: reload at the next edge, `remain` = 3; `r_end` high for one cycle exactly 12 edges later; `remain` = 0 afterward with no repeat pulse.
- **Green phase:**
  - Stimulus: `ph` switches 010 → 001 with TICK_DIV = 4.
  - Response: `remain` = 10, `g_end` at 40 edges; `y_end` and `r_end` stay 0.
- **Editing and wrap:**
  - Stimulus: `set_mode` = 1, `sel` = 1, then 97 `inc` pulses.
  - Response: `dur_y` goes 3 → 99 → 1 (wraps on the 97th pulse); `remain` tracks it when `ph` = 010; no end pulses throughout.
  - Stimulus: `inc` with `set_mode` = 0.
  - Response: no duration change.
- **Early phase change:**
  - Stimulus: `ph` = 010 with `cnt` = 2, then switch to 001 in the same cycle as a tick.
  - Response: `cnt` loads `dur_g`; no `y_end` is ever generated.
- **Illegal phase vector:**
  - Stimulus: `ph` = 011.
  - Response: state IDLE, `remain` = 0, `tick` = 0, no pulses. Returning to 100 reloads red.
- **Reset mid-count:**
  - Stimulus: `rst` = 0 for one cycle at `remain` = 5 after programming `dur_g` = 20.
  - Response: durations return to 3 / 3 / 10, outputs return to 0, and counting restarts from the reload.

Source files
------------

// File: rtl/phase_timer_if.sv
//------------------------------------------------------------------------------
// phase_timer_if : controller <-> phase timer signal bundle
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface phase_timer_if;
    logic       fsm_r;
    logic       fsm_y;
    logic       fsm_g;
    logic       set_mode;
    logic [1:0] sel;
    logic       inc;
    logic       r_end;
    logic       y_end;
    logic       g_end;
    logic [6:0] remain;
    logic       tick;

    modport master (
        output fsm_r, fsm_y, fsm_g, set_mode, sel, inc,
        input  r_end, y_end, g_end, remain, tick
    );

    modport slave (
        input  fsm_r, fsm_y, fsm_g, set_mode, sel, inc,
        output r_end, y_end, g_end, remain, tick
    );
endinterface

`default_nettype wire

// File: rtl/phase_timer.sv
//------------------------------------------------------------------------------
// phase_timer : per-phase seconds countdown with programmable durations
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module phase_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int R_DEF    = 3,
    parameter int Y_DEF    = 3,
    parameter int G_DEF    = 10
) (
    input  logic          clk,
    input  logic          rst,
    phase_timer_if.slave  bus
);

    localparam int                PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [6:0]        DUR_MAX = 7'd99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       dur_r_q, dur_r_d;
    logic [6:0]       dur_y_q, dur_y_d;
    logic [6:0]       dur_g_q, dur_g_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [2:0]       prev_q, prev_d;
    logic [2:0]       end_q, end_d;

    logic [2:0]       ph;
    logic             ph_legal;
    logic [6:0]       ph_dur;
    logic             tick;

    function automatic logic [6:0] bump(input logic [6:0] d);
        return (d == DUR_MAX) ? 7'd1 : d + 7'd1;
    endfunction

    assign ph   = {bus.fsm_r, bus.fsm_y, bus.fsm_g};
    assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

    always_comb begin
        ph_legal = 1'b0;
        ph_dur   = 7'd0;
        case (ph)
            3'b100:  begin ph_legal = 1'b1; ph_dur = dur_r_q; end
            3'b010:  begin ph_legal = 1'b1; ph_dur = dur_y_q; end
            3'b001:  begin ph_legal = 1'b1; ph_dur = dur_g_q; end
            default: begin ph_legal = 1'b0; ph_dur = 7'd0;    end
        endcase
    end

    always_comb begin
        state_d = state_q;
        dur_r_d = dur_r_q;
        dur_y_d = dur_y_q;
        dur_g_d = dur_g_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        prev_d  = prev_q;
        end_d   = 3'b000;

        if (bus.set_mode) begin
            // The load below uses the pre-edit duration; the edit shows up one cycle later.
            if (bus.inc) begin
                case (bus.sel)
                    2'd0:    dur_r_d = bump(dur_r_q);
                    2'd1:    dur_y_d = bump(dur_y_q);
                    2'd2:    dur_g_d = bump(dur_g_q);
                    default: ;
                endcase
            end
            cnt_d   = ph_dur;
            pre_d   = '0;
            prev_d  = ph;
            state_d = ph_legal ? RUN : IDLE;
        end else if (ph != prev_q) begin
            cnt_d   = ph_dur;
            pre_d   = '0;
            prev_d  = ph;
            state_d = ph_legal ? RUN : IDLE;
        end else if (state_q == RUN) begin
            if (tick) begin
                pre_d = '0;
                if (cnt_q > 7'd1) begin
                    cnt_d = cnt_q - 7'd1;
                end else begin
                    cnt_d   = 7'd0;
                    end_d   = prev_q;
                    state_d = DONE;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            dur_r_q <= 7'(R_DEF);
            dur_y_q <= 7'(Y_DEF);
            dur_g_q <= 7'(G_DEF);
            cnt_q   <= 7'd0;
            pre_q   <= '0;
            prev_q  <= 3'b000;
            end_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            dur_r_q <= dur_r_d;
            dur_y_q <= dur_y_d;
            dur_g_q <= dur_g_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            prev_q  <= prev_d;
            end_q   <= end_d;
        end
    end

    assign bus.r_end  = end_q[2];
    assign bus.y_end  = end_q[1];
    assign bus.g_end  = end_q[0];
    assign bus.remain = cnt_q;
    assign bus.tick   = tick;

endmodule

`default_nettype wire
